// File: rtl/ber_pkg.sv
// Shared types and width helpers for the PRBS bit-error-rate monitor.
// Optional build macro used by ber_lane: BER_POLARITY_DETECT_EN.
package ber_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lane_state_t;

  // Width of a latency index into a MAX_LAT-deep reference buffer.
  function automatic int lat_w(input int max_lat);
    return (max_lat > 1) ? $clog2(max_lat) : 1;
  endfunction

endpackage

// File: rtl/ber_lane.sv
// One monitor lane: reference buffer read, latency search / lock FSM, window and BER counters.
// BER_POLARITY_DETECT_EN defined: SEARCH also locks onto an inverted stream.
//
//   state  | meaning
//   SEARCH | stepping candidate latency until ALIGN_BITS consecutive agreements
//   LOCKED | counting compared bits and errors; LOSS_ERR errors in one window drop lock
module ber_lane
  import ber_pkg::*;
#(
  parameter int MAX_LAT    = 64,
  parameter int CNT_W      = 32,
  parameter int ALIGN_BITS = 128,
  parameter int LOSS_ERR   = 8,
  parameter int LW         = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clear,
  input  logic             ref_bit,
  input  logic             ref_valid,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic [LW-1:0]    wp,
  input  logic [LW:0]      fill,
  output logic             locked,
  output logic             inverted,
  output logic [LW-1:0]    latency,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(ALIGN_BITS + 1);
  localparam int EW = $clog2(LOSS_ERR + 1);

  lane_state_t       state;
  logic [LW-1:0]     lat;
  logic              inv;
  logic [MW-1:0]     match_cnt;
  logic [MW-1:0]     win_bits;
  logic [EW-1:0]     win_errs;
  logic [MAX_LAT-1:0] ref_buf;
  logic [LW-1:0]     rd_idx;
  logic              do_cmp;
  logic              mis;

  always_ff @(posedge clk) begin
    if (en && ref_valid) ref_buf[wp] <= ref_bit;
  end

  // wp and fill are pre-write values, so a bit written this cycle is never read.
  assign rd_idx = wp - LW'(1) - lat;
  assign do_cmp = en && rx_valid && (fill > {1'b0, lat});
  assign mis    = rx_bit ^ ref_buf[rd_idx] ^ inv;

`ifdef BER_POLARITY_DETECT_EN
  logic [MW-1:0] mis_cnt;
`else
  assign inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SEARCH;
      lat       <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
`ifdef BER_POLARITY_DETECT_EN
      inv       <= 1'b0;
      mis_cnt   <= '0;
`endif
    end else if (do_cmp) begin
      case (state)
        SEARCH: begin
`ifdef BER_POLARITY_DETECT_EN
          // A run only moves the latency once it is broken by the opposite sense.
          if (!mis) begin
            mis_cnt <= '0;
            if (mis_cnt != '0) begin
              lat       <= lat + LW'(1);
              match_cnt <= '0;
            end else if (match_cnt == MW'(ALIGN_BITS - 1)) begin
              state     <= LOCKED;
              match_cnt <= '0;
              win_bits  <= '0;
              win_errs  <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            match_cnt <= '0;
            if (match_cnt != '0) begin
              lat     <= lat + LW'(1);
              mis_cnt <= '0;
            end else if (mis_cnt == MW'(ALIGN_BITS - 1)) begin
              state    <= LOCKED;
              inv      <= 1'b1;
              mis_cnt  <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              mis_cnt <= mis_cnt + MW'(1);
            end
          end
`else
          if (mis) begin
            match_cnt <= '0;
            lat       <= lat + LW'(1);
          end else if (match_cnt == MW'(ALIGN_BITS - 1)) begin
            state     <= LOCKED;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
`endif
        end
        LOCKED: begin
          if (mis && (win_errs == EW'(LOSS_ERR - 1))) begin
            state     <= SEARCH;
            lat       <= lat + LW'(1);
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
`ifdef BER_POLARITY_DETECT_EN
            inv       <= 1'b0;
            mis_cnt   <= '0;
`endif
          end else if (win_bits == MW'(ALIGN_BITS - 1)) begin
            win_bits <= '0;
            win_errs <= '0;
          end else begin
            win_bits <= win_bits + MW'(1);
            if (mis) win_errs <= win_errs + EW'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (en) begin
      if (clear) begin
        bit_count <= '0;
        err_count <= '0;
      end else if (do_cmp && (state == LOCKED)) begin
        if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
        if (mis && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign locked   = (state == LOCKED);
  assign inverted = inv;
  assign latency  = lat;

endmodule

// File: rtl/prbs_ber_monitor.sv
// Multi-lane PRBS BER monitor: shared reference write pointer / fill level, one ber_lane per lane.
// Build macro BER_POLARITY_DETECT_EN enables inverted-polarity lock in each lane.
module prbs_ber_monitor
  import ber_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int MAX_LAT    = 64,
  parameter int CNT_W      = 32,
  parameter int ALIGN_BITS = 128,
  parameter int LOSS_ERR   = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            en,
  input  logic                            clear,
  input  logic [LANES-1:0]                ref_bit,
  input  logic                            ref_valid,
  input  logic [LANES-1:0]                rx_bit,
  input  logic                            rx_valid,
  output logic [LANES-1:0]                lane_locked,
  output logic [LANES-1:0]                lane_inverted,
  output logic [LANES*lat_w(MAX_LAT)-1:0] lane_latency,
  output logic [LANES*CNT_W-1:0]          bit_count,
  output logic [LANES*CNT_W-1:0]          err_count
);

  localparam int LW = lat_w(MAX_LAT);
  localparam logic [LW:0] FILL_MAX = (LW + 1)'(MAX_LAT);

  logic [LW-1:0] wp;
  logic [LW:0]   fill;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= '0;
      fill <= '0;
    end else if (en && ref_valid) begin
      wp <= wp + LW'(1);
      if (fill != FILL_MAX) fill <= fill + (LW + 1)'(1);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ber_lane #(
      .MAX_LAT   (MAX_LAT),
      .CNT_W     (CNT_W),
      .ALIGN_BITS(ALIGN_BITS),
      .LOSS_ERR  (LOSS_ERR),
      .LW        (LW)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .clear    (clear),
      .ref_bit  (ref_bit[g]),
      .ref_valid(ref_valid),
      .rx_bit   (rx_bit[g]),
      .rx_valid (rx_valid),
      .wp       (wp),
      .fill     (fill),
      .locked   (lane_locked[g]),
      .inverted (lane_inverted[g]),
      .latency  (lane_latency[g*LW +: LW]),
      .bit_count(bit_count[g*CNT_W +: CNT_W]),
      .err_count(err_count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// Directed bench for prbs_ber_monitor: latency table plus error/clear/enable/reset/saturation sequences.
// Latency L means rx on a cycle equals the ref bit sent L+1 valid cycles earlier.
`timescale 1ns/1ps
module tb_prbs_ber_monitor;

  localparam int LANES      = 2;
  localparam int MAX_LAT    = 16;
  localparam int CNT_W      = 6;
  localparam int ALIGN_BITS = 32;
  localparam int LOSS_ERR   = 4;
  localparam int LW         = 4;

  typedef struct {
    int d0;
    int d1;
    bit inv;
    bit exp_lock;
    bit exp_inv;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b1;
  logic                   en = 1'b0;
  logic                   clear = 1'b0;
  logic [LANES-1:0]       ref_bit = '0;
  logic                   ref_valid = 1'b0;
  logic [LANES-1:0]       rx_bit = '0;
  logic                   rx_valid = 1'b0;
  logic [LANES-1:0]       lane_locked;
  logic [LANES-1:0]       lane_inverted;
  logic [LANES*LW-1:0]    lane_latency;
  logic [LANES*CNT_W-1:0] bit_count;
  logic [LANES*CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  prbs_ber_monitor #(
    .LANES(LANES), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W),
    .ALIGN_BITS(ALIGN_BITS), .LOSS_ERR(LOSS_ERR)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear),
    .ref_bit(ref_bit), .ref_valid(ref_valid),
    .rx_bit(rx_bit), .rx_valid(rx_valid),
    .lane_locked(lane_locked), .lane_inverted(lane_inverted),
    .lane_latency(lane_latency), .bit_count(bit_count), .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;
  logic [6:0]       lfsr;
  logic [31:0]      hist;
  int               dly [LANES];
  logic [LANES-1:0] rx_inv;

  function automatic logic [LW-1:0] lat_of(input int i);
    return lane_latency[i*LW +: LW];
  endfunction
  function automatic logic [CNT_W-1:0] bc_of(input int i);
    return bit_count[i*CNT_W +: CNT_W];
  endfunction
  function automatic logic [CNT_W-1:0] ec_of(input int i);
    return err_count[i*CNT_W +: CNT_W];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One cycle of PRBS7 reference with per-lane delayed (optionally inverted/flipped) rx.
  task automatic step(input logic [LANES-1:0] flip, input logic clr, input logic vld);
    logic nb;
    nb = lfsr[6] ^ lfsr[5];
    ref_bit = {LANES{nb}};
    for (int i = 0; i < LANES; i++) rx_bit[i] = hist[dly[i]] ^ rx_inv[i] ^ flip[i];
    ref_valid = vld;
    rx_valid  = vld;
    clear     = clr;
    @(posedge clk);
    #1;
    clear = 1'b0;
    if (en && vld) begin
      lfsr = {lfsr[5:0], nb};
      hist = {hist[30:0], nb};
    end
  endtask

  task automatic restart(input int d0, input int d1, input logic [LANES-1:0] inv);
    rstn = 1'b0;
    en = 1'b0; ref_valid = 1'b0; rx_valid = 1'b0; clear = 1'b0;
    ref_bit = '0; rx_bit = '0;
    lfsr = 7'h7F; hist = '0;
    dly[0] = d0; dly[1] = d1; rx_inv = inv;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    en = 1'b1;
  endtask

  task automatic wait_lock();
    for (int c = 0; c < 400 && lane_locked != 2'b11; c++) step('0, 1'b0, 1'b1);
    check("lock_reached", lane_locked, 2'b11);
  endtask

  initial begin
    vec_t vecs [4];
    logic [LANES-1:0] f;
    vecs[0] = '{5, 5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3, 12, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 15, 1'b0, 1'b1, 1'b0};
`ifdef BER_POLARITY_DETECT_EN
    vecs[3] = '{7, 7, 1'b1, 1'b1, 1'b1};
`else
    vecs[3] = '{7, 7, 1'b1, 1'b0, 1'b0};
`endif

    for (int v = 0; v < 4; v++) begin
      restart(vecs[v].d0, vecs[v].d1, {vecs[v].inv, vecs[v].inv});
      check($sformatf("v%0d_reset_locked", v), lane_locked, 0);
      check($sformatf("v%0d_reset_bits", v), bit_count, 0);
      repeat (400) step('0, 1'b0, 1'b1);
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("v%0d_l%0d_locked", v, i), lane_locked[i], vecs[v].exp_lock);
        check($sformatf("v%0d_l%0d_inverted", v, i), lane_inverted[i], vecs[v].exp_inv);
        if (vecs[v].exp_lock) begin
          check($sformatf("v%0d_l%0d_latency", v, i), lat_of(i), (i == 0) ? vecs[v].d0 : vecs[v].d1);
          check($sformatf("v%0d_l%0d_errs", v, i), ec_of(i), 0);
        end
      end
    end

    // Error injection, clear priority and loss of lock; k counts compares after lock.
    restart(5, 5, '0);
    wait_lock();
    check("lock_bits_start", bc_of(0), 0);
    for (int k = 0; k <= 44; k++) begin
      f = '0;
      f[0] = ((k >= 2) && (k <= 4)) || ((k >= 40) && (k <= 43));
      f[1] = (k == 33);
      step(f, (k == 33), 1'b1);
      if (k == 0) check("incr_bits_k0", bc_of(0), 1);
      if (k == 1) check("incr_bits_k1", bc_of(0), 2);
      if (k == 31) begin
        check("three_err_count", ec_of(0), 3);
        check("three_err_bits", bc_of(0), 32);
        check("three_err_locked", lane_locked, 2'b11);
      end
      if (k == 33) begin
        check("clear_bits0", bc_of(0), 0);
        check("clear_errs0", ec_of(0), 0);
        check("clear_bits1", bc_of(1), 0);
        check("clear_errs1", ec_of(1), 0);
        check("clear_locked", lane_locked, 2'b11);
      end
      if (k == 42) check("pre_loss_locked", lane_locked[0], 1);
      if (k == 43) begin
        check("loss_locked0", lane_locked[0], 0);
        check("loss_locked1", lane_locked[1], 1);
        check("loss_latency0", lat_of(0), 6);
        check("loss_bits0", bc_of(0), 10);
        check("loss_errs0", ec_of(0), 4);
      end
      if (k == 44) begin
        check("retain_bits0", bc_of(0), 10);
        check("retain_errs0", ec_of(0), 4);
        check("lane1_bits", bc_of(1), 11);
        check("lane1_errs", ec_of(1), 0);
      end
    end

    // Enable low: everything frozen even with toggling valids and garbage rx.
    en = 1'b0;
    for (int c = 0; c < 50; c++) step(LANES'($urandom_range(0, 3)), 1'b0, c[0]);
    check("freeze_bits1", bc_of(1), 11);
    check("freeze_errs1", ec_of(1), 0);
    check("freeze_locked1", lane_locked[1], 1);
    check("freeze_latency1", lat_of(1), 5);
    en = 1'b1;
    step('0, 1'b0, 1'b1);
    check("resume_bits1", bc_of(1), 12);
    check("resume_errs1", ec_of(1), 0);

    // Asynchronous reset mid-lock, checked before any clock edge.
    #3;
    rstn = 1'b0;
    #1;
    check("rst_locked", lane_locked, 0);
    check("rst_inverted", lane_inverted, 0);
    check("rst_latency", lane_latency, 0);
    check("rst_bits", bit_count, 0);
    check("rst_errs", err_count, 0);

    // Saturation: bit_count pins at all-ones while err_count keeps climbing.
    restart(5, 5, '0);
    wait_lock();
    for (int k = 0; k < 700; k++) begin
      f = '0;
      f[0] = ((k % 32) >= 2) && ((k % 32) <= 4);
      step(f, 1'b0, 1'b1);
      if (k == 61) check("sat_bits_k61", bc_of(0), 62);
      if (k == 62) check("sat_bits_k62", bc_of(0), 63);
      if (k == 200) begin
        check("sat_bits_k200", bc_of(0), 63);
        check("sat_errs_k200", ec_of(0), 21);
      end
    end
    check("sat_errs_end", ec_of(0), 63);
    check("sat_bits_end", bc_of(0), 63);
    check("sat_bits1_end", bc_of(1), 63);
    check("sat_errs1_end", ec_of(1), 0);
    check("sat_locked_end", lane_locked, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
